// File: rtl/dot_seq_pkg.sv
// Shared types and width helpers for the dot step-pattern sequencer.
package dot_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACTIVE,
        S_DEAD,
        S_DONE
    } state_e;

    // Address width for a memory of the given depth; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dot_pattern_mem.sv
// DEPTH x NUM_DOTS pattern register file: synchronous write, combinational read.
module dot_pattern_mem #(
    parameter int NUM_DOTS = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic                clock,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [NUM_DOTS-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [NUM_DOTS-1:0] rd_data
);

    logic [DEPTH-1:0][NUM_DOTS-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
    end

    // Contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dot_sequencer.sv
// Plays a stored pattern step by step: FETCH, on-time with outputs enabled,
// optional dead-time with outputs disabled, then the next step.
module dot_sequencer
    import dot_seq_pkg::*;
#(
    parameter int NUM_DOTS = 8,
    parameter int DEPTH    = 16,
    parameter int TIME_W   = 16,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [NUM_DOTS-1:0] wr_data,
    input  logic [NUM_DOTS-1:0] dot_mask,
    input  logic [AW:0]         step_count,
    input  logic [TIME_W-1:0]   on_time,
    input  logic [TIME_W-1:0]   dead_time,
    input  logic                loop,
    input  logic                start,
    input  logic                stop,
    output logic [NUM_DOTS-1:0] dot_state,
    output logic [NUM_DOTS-1:0] dot_enable,
    output logic                output_enable,
    output logic                busy,
    output logic                done
);

    localparam logic [AW:0]     STEP_ONE = 1;
    localparam logic [TIME_W-1:0] T_ONE  = 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DOTS-1:0] mask_q, mask_d;
    logic [AW:0]         steps_q, steps_d;
    logic [TIME_W-1:0]   on_q, on_d;
    logic [TIME_W-1:0]   dead_q, dead_d;
    logic                loop_q, loop_d;
    logic [NUM_DOTS-1:0] ds_q, ds_d;
    logic [NUM_DOTS-1:0] en_q, en_d;
    logic                oe_q, oe_d;
    logic                done_q, done_d;
    logic                adv;
    logic                last_step;
    logic [NUM_DOTS-1:0] rd_data;

    dot_pattern_mem #(
        .NUM_DOTS (NUM_DOTS),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_mem (
        .clock    (clock),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (idx_q),
        .rd_data  (rd_data)
    );

    assign last_step = (({1'b0, idx_q} + STEP_ONE) >= steps_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        steps_d = steps_q;
        on_d    = on_q;
        dead_d  = dead_q;
        loop_d  = loop_q;
        ds_d    = ds_q;
        en_d    = en_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        adv     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = dot_mask;
                    steps_d = step_count;
                    on_d    = on_time;
                    dead_d  = dead_time;
                    loop_d  = loop;
                    idx_d   = '0;
                    if (step_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                ds_d    = rd_data;
                en_d    = mask_q;
                cnt_d   = (on_q == '0) ? '0 : on_q - T_ONE;
                oe_d    = 1'b1;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - T_ONE;
                end else begin
                    oe_d = 1'b0;
                    if (dead_q != '0) begin
                        state_d = S_DEAD;
                        cnt_d   = dead_q - T_ONE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (cnt_q != '0) cnt_d = cnt_q - T_ONE;
                else             adv   = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (!last_step) begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
                ds_d    = '0;
                en_d    = '0;
            end
        end

        // Abort wins over everything else, including a same-cycle start.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            ds_d    = '0;
            en_d    = '0;
            oe_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            steps_q <= '0;
            on_q    <= '0;
            dead_q  <= '0;
            loop_q  <= 1'b0;
            ds_q    <= '0;
            en_q    <= '0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            steps_q <= steps_d;
            on_q    <= on_d;
            dead_q  <= dead_d;
            loop_q  <= loop_d;
            ds_q    <= ds_d;
            en_q    <= en_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    assign dot_state     = ds_q;
    assign dot_enable    = en_q;
    assign output_enable = oe_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_dot_sequencer.sv
// Bench for dot_sequencer: directed scenarios plus random runs, checked every
// cycle against a timeline model (elapsed cycles -> step number and phase).
module tb_dot_sequencer;

    localparam int N  = 8;
    localparam int D  = 16;
    localparam int TW = 16;
    localparam int AW = 4;

    localparam int K_FETCH = 0;
    localparam int K_ON    = 1;
    localparam int K_DEAD  = 2;
    localparam int K_DONE  = 3;
    localparam int K_END   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic [N-1:0]  dot_mask = '0;
    logic [AW:0]   step_count = '0;
    logic [TW-1:0] on_time = '0;
    logic [TW-1:0] dead_time = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [N-1:0]  dot_state, dot_enable;
    logic          output_enable, busy, done;

    dot_sequencer #(.NUM_DOTS(N), .DEPTH(D), .TIME_W(TW)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .dot_mask(dot_mask), .step_count(step_count),
        .on_time(on_time), .dead_time(dead_time), .loop(loop), .start(start),
        .stop(stop), .dot_state(dot_state), .dot_enable(dot_enable),
        .output_enable(output_enable), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a run is just "t cycles since the accepted start".
    bit           run = 1'b0;
    int unsigned  t = 0;
    logic [N-1:0] c_mask;
    int unsigned  c_steps, c_on, c_dead;
    bit           c_loop;
    logic [N-1:0] cap = '0;
    logic [N-1:0] mem_m [D];

    function automatic int unsigned period();
        return 1 + c_on + c_dead;
    endfunction

    function automatic int unsigned step_no(int unsigned tt);
        return (tt - 1) / period();
    endfunction

    function automatic int unsigned idx_of(int unsigned tt);
        return step_no(tt) % c_steps;
    endfunction

    function automatic int kind_of(int unsigned tt);
        int unsigned sn, ph;
        if (c_steps == 0) return (tt == 1) ? K_DONE : K_END;
        sn = step_no(tt);
        ph = (tt - 1) % period();
        if (!c_loop && sn >= c_steps) return (sn == c_steps && ph == 0) ? K_DONE : K_END;
        if (ph == 0) return K_FETCH;
        if (ph <= c_on) return K_ON;
        return K_DEAD;
    endfunction

    task automatic model_edge();
        if (reset) begin
            run = 1'b0;
        end else if (run && stop) begin
            run = 1'b0;
        end else if (run) begin
            if (kind_of(t) == K_FETCH) cap = mem_m[idx_of(t)];
            t++;
            if (kind_of(t) == K_END) run = 1'b0;
        end else if (start) begin
            c_mask  = dot_mask;
            c_steps = step_count;
            c_on    = (on_time == 0) ? 1 : on_time;
            c_dead  = dead_time;
            c_loop  = loop;
            run     = 1'b1;
            t       = 1;
        end
        if (wr_en && !reset) mem_m[wr_addr] = wr_data;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_ds, e_en;
        logic e_oe, e_busy, e_done;
        int k;
        e_ds = '0; e_en = '0; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (run) begin
            k = kind_of(t);
            e_busy = 1'b1;
            case (k)
                K_FETCH: begin
                    e_ds = (step_no(t) == 0) ? '0 : cap;
                    e_en = (step_no(t) == 0) ? '0 : c_mask;
                end
                K_ON:    begin e_ds = cap; e_en = c_mask; e_oe = 1'b1; end
                K_DEAD:  begin e_ds = cap; e_en = c_mask; end
                K_DONE:  e_done = 1'b1;
                default: e_busy = 1'b0;
            endcase
        end
        chk("dot_state",     dot_state,     e_ds);
        chk("dot_enable",    dot_enable,    e_en);
        chk("output_enable", output_enable, e_oe);
        chk("busy",          busy,          e_busy);
        chk("done",          done,          e_done);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #2;
        check_outputs();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; reset = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model is in phase k (of step want_idx, or any if -1).
    task automatic wait_phase(input int k, input int want_idx, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (run && kind_of(t) == k && (want_idx < 0 || (c_steps != 0 && idx_of(t) == want_idx)))
                hit = 1'b1;
            else
                step();
        end
        n_assert++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL wait_phase kind %0d idx %0d: got timeout expected hit", k, want_idx);
        end
    endtask

    task automatic cfg(input int sc, input int on, input int dead, input bit lp, input logic [N-1:0] m);
        step_count = sc; on_time = on; dead_time = dead; loop = lp; dot_mask = m;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; step();
        reset = 1'b1; step();

        for (int a = 0; a < D; a++) begin
            wr_en = 1'b1; wr_addr = a; wr_data = $urandom; step();
        end
        wr_en = 1'b1; wr_addr = 0; wr_data = 8'hA5; step();
        wr_en = 1'b1; wr_addr = 1; wr_data = 8'h3C; step();

        // Two steps, on 3, dead 2, no loop.
        cfg(2, 3, 2, 1'b0, 8'hFF); start = 1'b1;
        run_cycles(16);

        // Minimum timing, back-to-back starts.
        cfg(1, 0, 0, 1'b0, 8'h5A); start = 1'b1;
        run_cycles(3);
        start = 1'b1;
        run_cycles(4);

        // Loop mode, then abort mid-ACTIVE.
        cfg(2, 2, 1, 1'b1, 8'hF0); start = 1'b1;
        run_cycles(18);
        wait_phase(K_ON, -1, 10);
        stop = 1'b1; step();
        run_cycles(2);

        // Zero steps: done only.
        cfg(0, 3, 3, 1'b0, 8'hFF); start = 1'b1;
        run_cycles(4);

        // Rewrite a playing step and try to restart while busy.
        cfg(2, 4, 1, 1'b1, 8'h0F); start = 1'b1; step();
        wait_phase(K_ON, 1, 30);
        wr_en = 1'b1; wr_addr = 1; wr_data = 8'hC3; start = 1'b1; step();
        run_cycles(24);
        stop = 1'b1; step();
        step();

        // Reset during DEAD, then replay from step 0.
        cfg(3, 2, 3, 1'b0, 8'hAA); start = 1'b1; step();
        wait_phase(K_DEAD, -1, 20);
        reset = 1'b1; step();
        start = 1'b1;
        run_cycles(22);

        // Random configurations, writes, restarts and aborts.
        for (int r = 0; r < 8; r++) begin
            cfg($urandom_range(0, 16), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 8'($urandom));
            start = 1'b1;
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 8'($urandom);
                end
                if ($urandom_range(0, 59) == 0) stop = 1'b1;
                if ($urandom_range(0, 19) == 0) start = 1'b1;
                step();
            end
            stop = 1'b1; step();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_sequencer.md
Name: dot_sequencer

Overview:
Step-pattern player that produces the per-dot command signals (dot_state, dot_enable, output_enable) consumed by the dot driver array. It holds a small pattern memory of dot states and plays it step by step. Each step has a programmable on-time, followed by a dead-time with outputs disabled so actuators never switch while enabled. It sits between the host/config interface and the bank of dot drivers.

Parameters:
NUM_DOTS, 8, number of dots driven; width of each pattern word
DEPTH, 16, number of pattern steps in memory (power of 2)
TIME_W, 16, width of on-time and dead-time counters

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  pattern memory write strobe
wr_addr  input  log2(DEPTH)  pattern write address
wr_data  input  NUM_DOTS  pattern word (bit i = state of dot i)
dot_mask  input  NUM_DOTS  per-dot enable mask, sampled at start
step_count  input  log2(DEPTH)+1  number of steps to play (0..DEPTH)
on_time  input  TIME_W  cycles output_enable is high per step (0 treated as 1)
dead_time  input  TIME_W  cycles output_enable is low between steps (0 = no gap)
loop  input  1  replay from step 0 after the last step
start  input  1  single-cycle start request
stop  input  1  single-cycle abort request
dot_state  output  NUM_DOTS  registered pattern word for current step
dot_enable  output  NUM_DOTS  registered latched dot_mask while running, else 0
output_enable  output  1  registered; high only during ACTIVE cycles
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE; dot_state=0, dot_enable=0, output_enable=0, busy=0, done=0, step index=0, counters=0. Memory contents are not reset.
- Writes: when wr_en=1, mem[wr_addr]<=wr_data in any state. A write to the step currently playing takes effect only at that step's next FETCH.
- Config (dot_mask, step_count, on_time, dead_time, loop) is latched on an accepted start and held until return to IDLE.
- States: IDLE, FETCH, ACTIVE, DEAD, DONE.
- IDLE: start=1 and step_count!=0 -> FETCH, index=0. start=1 and step_count=0 -> DONE (done pulses, no output activity).
- FETCH (1 cycle): dot_state<=mem[index]; dot_enable<=latched mask; on-counter loaded with max(on_time,1)-1; output_enable=0 -> ACTIVE.
- ACTIVE: output_enable=1. Stay until on-counter reaches 0, then -> DEAD if dead_time!=0, else advance.
- DEAD: output_enable=0, dot_state held, counts dead_time cycles, then advance.
- Advance: if index+1 < step_count -> index+1, FETCH. Otherwise, if loop -> index=0, FETCH; if not loop -> DONE.
- DONE (1 cycle): done=1, dot_state<=0, dot_enable<=0, output_enable=0 -> IDLE.
- Timing: start sampled at edge k -> FETCH during cycle k+1 -> output_enable high for exactly max(on_time,1) cycles starting at cycle k+2. The step period is 1 + max(on_time,1) + dead_time cycles.
- stop: in any non-IDLE state, the next edge gives IDLE, output_enable=0, dot_state=0, dot_enable=0, and no done pulse. stop beats start in the same cycle. stop in IDLE is ignored.
- start while busy is ignored. Loop mode runs until stop.
- reset mid-run behaves identically to power-on reset.
- output_enable never rises in the same cycle that dot_state changes; FETCH always separates them.

Decomposition:
- Shared package dot_seq_pkg: state enum encoding, clog2-derived address/count widths.
- One natural sub-module, dot_pattern_mem: DEPTH x NUM_DOTS register file with synchronous write and combinational read. FETCH registers its output.
- Counters and FSM stay in dot_sequencer.

Test Plan:
- Write mem[0]=0xA5, mem[1]=0x3C; start with step_count=2, on_time=3, dead_time=2, mask=0xFF, loop=0 -> oe high cycles 2-4 with dot_state=0xA5, low 5-7, high 8-10 with 0x3C, low 11-12, done pulse at cycle 13, outputs 0 after.
- on_time=0, dead_time=0, step_count=1 -> oe high exactly 1 cycle, then done; FETCH gap visible between starts.
- loop=1, step_count=2 -> steps replay 0,1,0,1; assert stop mid-ACTIVE -> next cycle oe=0, dot_state=0, busy=0, no done.
- step_count=0 start -> done pulses one cycle after start; oe never asserts.
- Write mem[1] while step 1 is ACTIVE in loop mode -> new value appears only at the next FETCH of step 1. Assert start while busy -> no effect.
- Assert reset during DEAD -> all outputs 0 next cycle. A start issued after reset replays from step 0.
